reg_file_dumper: RTL and testbench
==================================

REG_FILE_DUMPER -- requirements
Module: reg_file_dumper

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register word width SHALL apply to rdata, wdata and out_data.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width SHALL apply to raddr, waddr and out_idx; register count is 2^ADDR_WIDTH.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle operation request, sampled only in IDLE.
REQ-007 mode  in  1  operation select sampled with start: 0 = dump, 1 = clear.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse on operation completion.
REQ-010 raddr  out  ADDR_WIDTH  read address to the register file.
REQ-011 rdata  in  DATA_WIDTH  combinational read data from the register file.
REQ-012 wen  out  1  register file write enable.
REQ-013 waddr  out  ADDR_WIDTH  register file write address.
REQ-014 wdata  out  DATA_WIDTH  register file write data; constant zero.
REQ-015 out_valid  out  1  dump word valid.
REQ-016 out_ready  in  1  downstream accepts the dump word.
REQ-017 out_data  out  DATA_WIDTH  registered dump word.
REQ-018 out_idx  out  ADDR_WIDTH  register index of out_data.

Function
REQ-019 The FSM SHALL have the states IDLE, RD, WAIT, CLR and FIN, and SHALL use a counter idx of width ADDR_WIDTH.
REQ-020 In IDLE with start=1 and mode=0, the block SHALL set idx=0 and go to RD; with start=1 and mode=1, it SHALL set idx=1 and go to CLR.
REQ-021 In IDLE, start=0 SHALL hold the state.
REQ-022 In RD, raddr SHALL equal idx; at the clock edge the block SHALL capture out_data<=rdata and out_idx<=idx, set out_valid<=1 and go to WAIT.
REQ-023 Outside RD, raddr SHALL be 0.
REQ-024 In WAIT, out_valid, out_data and out_idx SHALL be held stable until out_valid and out_ready are both high at a clock edge.
REQ-025 On a WAIT handshake, out_valid SHALL go to 0; if idx = 2^ADDR_WIDTH-1 the FSM SHALL go to FIN, otherwise it SHALL increment idx and return to RD.
REQ-026 out_ready SHALL be ignored outside WAIT.
REQ-027 Each dumped word SHALL take at least 2 cycles (RD then WAIT); a full dump with out_ready tied high SHALL take 64 cycles from start to entering FIN.
REQ-028 Index 0 SHALL be dumped as read; the block SHALL NOT substitute a value for it.
REQ-029 In CLR, the block SHALL drive wen=1, waddr=idx and wdata=0 each cycle; at idx = 2^ADDR_WIDTH-1 it SHALL go to FIN, otherwise it SHALL increment idx.
REQ-030 Index 0 SHALL never be written; the clear operation SHALL issue exactly 31 writes.
REQ-031 Outside CLR, wen SHALL be 0 and waddr SHALL be 0.
REQ-032 In FIN, done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-033 start SHALL be ignored while busy=1; an operation SHALL never be restarted or queued.
REQ-034 idx SHALL NOT wrap past 2^ADDR_WIDTH-1 within an operation.

Reset
REQ-035 While rst=1, asynchronously, the block SHALL force state=IDLE, idx=0, busy=0, done=0, out_valid=0, out_data=0, out_idx=0, wen=0, waddr=0 and raddr=0.
REQ-036 Reset asserted mid-dump or mid-clear SHALL abort the operation with no further writes and no done pulse; the register file contents already written SHALL remain as written.
REQ-037 After rst is released, the block SHALL accept start on the first rising edge.

Verification
REQ-038 The bench SHALL cover: register model with x[i]=0x100+i, start with mode=0 and out_ready=1 -> 32 words with out_idx 0..31 and out_data 0x100..0x11F in order, done 64 cycles after start, busy low the cycle after done.
REQ-039 The bench SHALL cover: same dump with out_ready toggling 1 cycle on / 3 cycles off -> identical word sequence, out_data stable while out_valid=1 and out_ready=0, no word dropped or duplicated.
REQ-040 The bench SHALL cover: start with mode=1 -> wen high for 31 consecutive cycles with waddr 1..31 and wdata=0, waddr never 0; a following dump returns all zeros except index 0 as modelled.
REQ-041 The bench SHALL cover: start pulsed again at word 10 of a dump -> ignored, and the dump completes normally with one done pulse.
REQ-042 The bench SHALL cover: rst asserted during CLR at waddr=12 -> wen drops immediately (asynchronously), registers 13..31 are unchanged, no done pulse, and a new start is accepted after release.
REQ-043 The bench SHALL cover: rst asserted in WAIT -> out_valid=0 immediately; a subsequent dump restarts from out_idx=0.

Source files
------------

// File: rtl/reg_file_dumper.sv
// Register file dumper: streams every register over a valid/ready port (dump)
// or zeroes registers 1..2^ADDR_WIDTH-1 with one write per cycle (clear).
module reg_file_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, CLR, FIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;

  assign wdata = '0;

  // All outputs are registered; raddr/waddr are loaded one edge ahead so they
  // already equal idx during the RD/CLR cycle that uses them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      wen       <= 1'b0;
      waddr     <= '0;
      raddr     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (mode) begin
              // Register 0 is never cleared, so the sweep starts at 1.
              idx   <= IDX_ONE;
              wen   <= 1'b1;
              waddr <= IDX_ONE;
              state <= CLR;
            end else begin
              idx   <= '0;
              raddr <= '0;
              state <= RD;
            end
          end
        end
        RD: begin
          out_data  <= rdata;
          out_idx   <= idx;
          out_valid <= 1'b1;
          raddr     <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx   <= idx + IDX_ONE;
              raddr <= idx + IDX_ONE;
              state <= RD;
            end
          end
        end
        CLR: begin
          if (idx == IDX_LAST) begin
            wen   <= 1'b0;
            waddr <= '0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx   <= idx + IDX_ONE;
            waddr <= idx + IDX_ONE;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          wen       <= 1'b0;
          waddr     <= '0;
          raddr     <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Bench for reg_file_dumper: behavioural register file, scoreboard of dumped
// words and issued writes, checked against a golden array of register contents.
module tb_reg_file_dumper;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, wen, out_valid;
  logic [AW-1:0] raddr, waddr, out_idx;
  logic [DW-1:0] rdata, wdata, out_data;

  logic [DW-1:0] rf   [N];
  logic [DW-1:0] gold [N];
  logic          init_req  = 1'b0;
  logic [DW-1:0] init_base = '0;

  int pcnt = 0;
  int rdy_mode = 0;
  int ph = 0;
  int errors = 0;
  int checks = 0;
  int start_stamp = 0;
  int done_stamp = 0;

  typedef struct {int stamp; logic hs; logic [AW-1:0] idx; logic [DW-1:0] data;} vrec_t;
  typedef struct {int stamp; logic [AW-1:0] addr; logic [DW-1:0] data;} wrec_t;
  typedef struct {logic mode; int rdy; logic do_init; logic [DW-1:0] base; int lat;} vec_t;

  vrec_t vlog[$];
  wrec_t wlog[$];
  int    dlog[$];
  vec_t  vecs[6];

  reg_file_dumper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .raddr(raddr), .rdata(rdata), .wen(wen), .waddr(waddr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  assign rdata = rf[raddr];

  always @(posedge clk) begin
    pcnt <= pcnt + 1;
    if (init_req) begin
      for (int i = 0; i < N; i++) rf[i] <= init_base + DW'(i);
    end else if (wen) begin
      rf[waddr] <= wdata;
    end
  end

  function automatic vrec_t mk_v(int s, logic h, logic [AW-1:0] i, logic [DW-1:0] d);
    vrec_t r;
    r.stamp = s; r.hs = h; r.idx = i; r.data = d;
    return r;
  endfunction

  function automatic wrec_t mk_w(int s, logic [AW-1:0] a, logic [DW-1:0] d);
    wrec_t r;
    r.stamp = s; r.addr = a; r.data = d;
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_valid) vlog.push_back(mk_v(pcnt, out_ready, out_idx, out_data));
    if (wen) wlog.push_back(mk_w(pcnt, waddr, wdata));
    if (done) dlog.push_back(pcnt);
  end

  // out_ready patterns: 0 always high, 1 one-on/three-off, 2 random, 3 low
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = (ph == 0);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_init(input logic [DW-1:0] base);
    @(posedge clk); #1;
    init_base = base;
    init_req  = 1'b1;
    @(posedge clk); #1;
    init_req  = 1'b0;
    for (int i = 0; i < N; i++) gold[i] = base + DW'(i);
  endtask

  task automatic start_op(input logic m, input logic rel);
    @(posedge clk); #1;
    if (rel) rst = 1'b0;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start_stamp = pcnt;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        done_stamp = pcnt;
      end
    end
  endtask

  function automatic int count_hs(input int vb);
    int k = 0;
    for (int j = vb; j < vlog.size(); j++) if (vlog[j].hs) k++;
    return k;
  endfunction

  task automatic check_rf(input string t);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s rf[%0d]", t, i), rf[i], gold[i]);
  endtask

  task automatic check_dump(input int vb, input string t);
    int k = 0;
    logic [95:0] nxt;
    for (int j = vb; j < vlog.size(); j++) begin
      if (vlog[j].hs) begin
        if (k < N)
          chk($sformatf("%s word%0d", t, k), {vlog[j].idx, vlog[j].data}, {AW'(k), gold[k]});
        k++;
      end else begin
        nxt = '0;
        if (j + 1 < vlog.size()) nxt = {vlog[j+1].stamp, vlog[j+1].idx, vlog[j+1].data};
        chk($sformatf("%s hold@%0d", t, vlog[j].stamp), nxt,
            {vlog[j].stamp + 1, vlog[j].idx, vlog[j].data});
      end
    end
    chk($sformatf("%s word count", t), k, N);
  endtask

  task automatic finish_op(input vec_t v, input string t, input int vb, input int wb, input int db);
    bit ok;
    wait_done(2000, ok);
    chk($sformatf("%s done seen", t), ok, 1'b1);
    if (v.lat >= 0) chk($sformatf("%s latency", t), done_stamp - start_stamp, v.lat);
    @(negedge clk);
    chk($sformatf("%s busy after done", t), busy, 1'b0);
    chk($sformatf("%s done one cycle", t), done, 1'b0);
    repeat (4) @(negedge clk);
    chk($sformatf("%s done pulses", t), dlog.size() - db, 1);
    if (!v.mode) begin
      check_dump(vb, t);
      chk($sformatf("%s writes during dump", t), wlog.size() - wb, 0);
    end else begin
      chk($sformatf("%s words during clear", t), vlog.size() - vb, 0);
      chk($sformatf("%s write count", t), wlog.size() - wb, N - 1);
      for (int j = 0; j < wlog.size() - wb; j++)
        chk($sformatf("%s write%0d", t, j),
            {wlog[wb+j].stamp, wlog[wb+j].addr, wlog[wb+j].data},
            {start_stamp + j, AW'(j + 1), DW'(0)});
      for (int i = 1; i < N; i++) gold[i] = '0;
      check_rf(t);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int vb, wb, db;
    string t;
    t = $sformatf("vec%0d", n);
    if (v.do_init) do_init(v.base);
    rdy_mode = v.rdy;
    vb = vlog.size(); wb = wlog.size(); db = dlog.size();
    start_op(v.mode, 1'b0);
    chk($sformatf("%s busy after start", t), busy, 1'b1);
    finish_op(v, t, vb, wb, db);
  endtask

  initial begin
    bit ok;
    int vb, wb, db;
    vec_t v;

    vecs[0] = '{1'b0, 0, 1'b1, 32'h100, 64};
    vecs[1] = '{1'b0, 1, 1'b0, 32'h0,   -1};
    vecs[2] = '{1'b1, 0, 1'b0, 32'h0,   31};
    vecs[3] = '{1'b0, 2, 1'b0, 32'h0,   -1};
    vecs[4] = '{1'b1, 2, 1'b1, 32'h300, 31};
    vecs[5] = '{1'b0, 0, 1'b0, 32'h0,   64};

    repeat (2) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset wen", wen, 1'b0);
    chk("reset waddr/raddr/out_idx", {waddr, raddr, out_idx}, 0);
    chk("reset out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int n = 0; n < 6; n++) run_vec(vecs[n], n);

    for (int r = 0; r < 4; r++) begin
      v.mode    = 1'($urandom_range(0, 1));
      v.rdy     = $urandom_range(0, 2);
      v.do_init = 1'b1;
      v.base    = $urandom;
      v.lat     = v.mode ? 31 : (v.rdy == 0 ? 64 : -1);
      run_vec(v, 10 + r);
    end

    // start pulsed (as a clear) in the middle of a dump must be ignored
    do_init(32'h100);
    rdy_mode = 0;
    vb = vlog.size(); wb = wlog.size(); db = dlog.size();
    start_op(1'b0, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (count_hs(vb) >= 10) ok = 1'b1;
    end
    chk("restart reached word 10", ok, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    v = '{1'b0, 0, 1'b0, 32'h0, 64};
    finish_op(v, "restart", vb, wb, db);

    // reset while a word is stalled in WAIT
    do_init(32'h5a5a0000);
    rdy_mode = 0;
    vb = vlog.size(); db = dlog.size();
    start_op(1'b0, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (count_hs(vb) >= 5) ok = 1'b1;
    end
    rdy_mode = 3;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (out_valid && !out_ready) ok = 1'b1;
    end
    chk("wait-reset stalled", ok, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("wait-reset out_valid", out_valid, 1'b0);
    chk("wait-reset out_data", out_data, 0);
    chk("wait-reset out_idx", out_idx, 0);
    chk("wait-reset busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("wait-reset no done", dlog.size() - db, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec('{1'b0, 0, 1'b0, 32'h0, 64}, 20);

    // reset in the middle of a clear at waddr 12
    do_init(32'h200);
    rdy_mode = 0;
    wb = wlog.size(); db = dlog.size();
    start_op(1'b1, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (waddr == AW'(12)) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("clr-reset reached 12", ok, 1'b1);
    rst = 1'b1;
    #1;
    chk("clr-reset wen", wen, 1'b0);
    chk("clr-reset waddr", waddr, 0);
    chk("clr-reset busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("clr-reset write count", wlog.size() - wb, 11);
    chk("clr-reset no done", dlog.size() - db, 0);
    for (int i = 1; i <= 11; i++) gold[i] = '0;
    check_rf("clr-reset");
    vb = vlog.size(); wb = wlog.size(); db = dlog.size();
    start_op(1'b0, 1'b1);
    chk("start on first edge after release", busy, 1'b1);
    v = '{1'b0, 0, 1'b0, 32'h0, 64};
    finish_op(v, "post-reset dump", vb, wb, db);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
